// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle instruction-fetch sequencer owning the MIPS program counter.
// Each instruction: request the word from instruction memory, latch it, give the
// datapath one commit cycle, then load the next PC or stop in HALT/ERR.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        halt_req,
  output logic        commit,
  output logic [31:0] retired,
  output logic        halted,
  output logic        bus_err,
  output logic        align_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // The FETCH cycle counts as request cycle 1, so the last WAIT cycle that may
  // still accept an ack is the one where the counter reads TIMEOUT-1.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  wait_cnt_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] retired_reg;
  logic        im_req_reg;
  logic        halted_reg;
  logic        bus_err_reg;
  logic        align_err_reg;

  // Decisions taken in EXEC; shared by the combinational commit and the FSM.
  logic exec_go;
  logic misaligned;
  logic commit_next;

  // Commit is the only combinational output: EXEC, not stalled, and either a
  // halt (which retires regardless of npc) or a word-aligned next PC.
  always_comb begin
    exec_go     = (state_reg == S_EXEC) && !stall;
    misaligned  = (npc[1:0] != 2'b00);
    commit_next = exec_go && (halt_req || !misaligned);
  end

  // Sequencer: state, PC, latched instruction, retire counter and sticky flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      wait_cnt_reg  <= 8'd0;
      pc_reg        <= RESET_PC;
      instr_reg     <= 32'd0;
      retired_reg   <= 32'd0;
      im_req_reg    <= 1'b0;
      halted_reg    <= 1'b0;
      bus_err_reg   <= 1'b0;
      align_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg  <= S_FETCH;
            im_req_reg <= 1'b1;
          end
        end

        S_FETCH: begin
          wait_cnt_reg <= 8'd1;
          if (im_ack) begin
            instr_reg  <= im_rdata;
            state_reg  <= S_EXEC;
            im_req_reg <= 1'b0;
          end else begin
            state_reg <= S_WAIT;
          end
        end

        S_WAIT: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (im_ack) begin
            instr_reg  <= im_rdata;
            state_reg  <= S_EXEC;
            im_req_reg <= 1'b0;
          end else if (wait_cnt_reg == LAST_WAIT) begin
            bus_err_reg <= 1'b1;
            state_reg   <= S_ERR;
            im_req_reg  <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        S_EXEC: begin
          // A stall holds everything; otherwise halt beats the alignment check.
          if (exec_go) begin
            if (halt_req) begin
              retired_reg <= retired_reg + 32'd1;
              halted_reg  <= 1'b1;
              state_reg   <= S_HALT;
            end else if (misaligned) begin
              // The instruction is aborted: pc and retired stay put.
              align_err_reg <= 1'b1;
              state_reg     <= S_ERR;
            end else begin
              pc_reg      <= npc;
              retired_reg <= retired_reg + 32'd1;
              state_reg   <= S_FETCH;
              im_req_reg  <= 1'b1;
            end
          end
        end

        S_HALT, S_ERR: begin
          // Terminal: only reset leaves these states.
          im_req_reg <= 1'b0;
        end

        default: begin
          state_reg  <= S_IDLE;
          im_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign im_req    = im_req_reg;
  assign im_addr   = pc_reg;
  assign pc        = pc_reg;
  assign instr     = instr_reg;
  assign retired   = retired_reg;
  assign halted    = halted_reg;
  assign bus_err   = bus_err_reg;
  assign align_err = align_err_reg;
  assign commit    = commit_next;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors with hand-computed expectations for fetch_ctrl
// (TIMEOUT=4 so the timeout boundary is reachable in a few cycles).
module tb_fetch_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        stall;
  logic        halt_req;
  logic        commit;
  logic [31:0] retired;
  logic        halted;
  logic        bus_err;
  logic        align_err;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ack   (im_ack),
    .im_rdata (im_rdata),
    .instr    (instr),
    .pc       (pc),
    .npc      (npc),
    .stall    (stall),
    .halt_req (halt_req),
    .commit   (commit),
    .retired  (retired),
    .halted   (halted),
    .bus_err  (bus_err),
    .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rstn = 1'b0; start = 1'b0; im_ack = 1'b0; stall = 1'b0; halt_req = 1'b0;
    step();
    rstn = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; im_ack = 1'b0; im_rdata = 32'd0;
    npc = 32'd0; stall = 1'b0; halt_req = 1'b0;

    // 1. Reset and idle
    repeat (3) step();
    rstn = 1'b1;
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", im_addr, 32'h0);
    chk("rst_req", {31'd0, im_req}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_flags", {29'd0, halted, bus_err, align_err}, 32'd0);
    chk("rst_commit", {31'd0, commit}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_req", {31'd0, im_req}, 32'd0);
    end

    // 2. Zero-wait sequence, npc = pc + 4
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("zw_addr", im_addr, 32'(i * 4));
      chk("zw_req", {31'd0, im_req}, 32'd1);
      im_ack = 1'b1; im_rdata = 32'h2000_0000 + 32'(i);
      #1 chk("zw_fetch_commit", {31'd0, commit}, 32'd0);
      step();
      im_ack = 1'b0;
      chk("zw_instr", instr, 32'h2000_0000 + 32'(i));
      chk("zw_exec_req", {31'd0, im_req}, 32'd0);
      npc = 32'(i * 4 + 4);
      #1 chk("zw_commit", {31'd0, commit}, 32'd1);
      step();
      chk("zw_retired", retired, 32'(i + 1));
      chk("zw_pc", pc, 32'(i * 4 + 4));
    end

    // 3. Wait states (ack in the 4th request cycle) and 2 stall cycles
    for (int c = 1; c <= 4; c++) begin
      chk("ws_req", {31'd0, im_req}, 32'd1);
      chk("ws_addr", im_addr, 32'h10);
      chk("ws_bus_err", {31'd0, bus_err}, 32'd0);
      if (c == 4) begin
        im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
      end else begin
        im_ack = 1'b0; im_rdata = 32'h0BAD_0000 + 32'(c);
      end
      #1 chk("ws_commit", {31'd0, commit}, 32'd0);
      step();
    end
    im_ack = 1'b0;
    chk("ws_exec_req", {31'd0, im_req}, 32'd0);
    chk("ws_instr", instr, 32'hDEAD_BEEF);
    stall = 1'b1; npc = 32'h14;
    #1 chk("st_commit1", {31'd0, commit}, 32'd0);
    step();
    chk("st_pc_hold", pc, 32'h10);
    chk("st_ret_hold", retired, 32'd4);
    im_ack = 1'b1; im_rdata = 32'h1234_5678;
    #1 chk("st_commit2", {31'd0, commit}, 32'd0);
    step();
    im_ack = 1'b0; stall = 1'b0;
    chk("st_instr_hold", instr, 32'hDEAD_BEEF);
    #1 chk("st_commit3", {31'd0, commit}, 32'd1);
    step();
    chk("st_pc", pc, 32'h14);
    chk("st_retired", retired, 32'd5);
    chk("st_next_req", {31'd0, im_req}, 32'd1);

    // 4. Reset beats start, then branch and misalignment
    rstn = 1'b0; start = 1'b1;
    step();
    chk("rs_req", {31'd0, im_req}, 32'd0);
    chk("rs_pc", pc, 32'h0);
    chk("rs_retired", retired, 32'd0);
    rstn = 1'b1;
    step();
    start = 1'b0;
    chk("br_req0", {31'd0, im_req}, 32'd1);
    chk("br_addr0", im_addr, 32'h0);
    im_ack = 1'b1; im_rdata = 32'h0800_0010;
    step();
    im_ack = 1'b0; npc = 32'h40;
    #1 chk("br_commit", {31'd0, commit}, 32'd1);
    step();
    chk("br_addr1", im_addr, 32'h40);
    chk("br_req1", {31'd0, im_req}, 32'd1);
    chk("br_retired", retired, 32'd1);
    im_ack = 1'b1; im_rdata = 32'h0000_0123;
    step();
    im_ack = 1'b0; npc = 32'h46;
    #1 chk("al_commit", {31'd0, commit}, 32'd0);
    step();
    chk("al_flag", {31'd0, align_err}, 32'd1);
    chk("al_pc", pc, 32'h40);
    chk("al_retired", retired, 32'd1);
    chk("al_req", {31'd0, im_req}, 32'd0);
    chk("al_commit_err", {31'd0, commit}, 32'd0);
    chk("al_other_flags", {30'd0, halted, bus_err}, 32'd0);
    im_ack = 1'b1; im_rdata = 32'hFFFF_0000;
    step();
    im_ack = 1'b0;
    chk("al_instr_hold", instr, 32'h0000_0123);
    chk("al_req_hold", {31'd0, im_req}, 32'd0);
    chk("al_pc_hold", pc, 32'h40);

    // 5. Timeout: no ack for 4 request cycles
    restart();
    for (int c = 1; c <= 4; c++) begin
      chk("to_req", {31'd0, im_req}, 32'd1);
      chk("to_bus_err_pre", {31'd0, bus_err}, 32'd0);
      step();
    end
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_req_drop", {31'd0, im_req}, 32'd0);
    step();
    chk("to_req_hold", {31'd0, im_req}, 32'd0);
    chk("to_align", {31'd0, align_err}, 32'd0);

    // 5b. Ack on the 4th request cycle completes normally
    restart();
    for (int c = 1; c <= 4; c++) begin
      chk("tb_req", {31'd0, im_req}, 32'd1);
      if (c == 4) begin
        im_ack = 1'b1; im_rdata = 32'hA5A5_0004;
      end
      step();
    end
    im_ack = 1'b0;
    chk("tb_req_drop", {31'd0, im_req}, 32'd0);
    chk("tb_bus_err", {31'd0, bus_err}, 32'd0);
    chk("tb_instr", instr, 32'hA5A5_0004);

    // 6. Halt (misaligned npc must not matter)
    halt_req = 1'b1; npc = 32'h3;
    #1 chk("h_commit", {31'd0, commit}, 32'd1);
    step();
    chk("h_halted", {31'd0, halted}, 32'd1);
    chk("h_pc", pc, 32'h0);
    chk("h_retired", retired, 32'd1);
    chk("h_align", {31'd0, align_err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("h_req", {31'd0, im_req}, 32'd0);
      #1 chk("h_commit_off", {31'd0, commit}, 32'd0);
      step();
    end
    chk("h_pc_frozen", pc, 32'h0);
    chk("h_ret_frozen", retired, 32'd1);
    halt_req = 1'b0;

    // 6b. Reset during WAIT; a late ack is ignored
    restart();
    im_ack = 1'b1; im_rdata = 32'hCAFE_F00D;
    step();
    im_ack = 1'b0; npc = 32'h4;
    step();
    step();
    chk("mw_req", {31'd0, im_req}, 32'd1);
    chk("mw_instr", instr, 32'hCAFE_F00D);
    chk("mw_pc", pc, 32'h4);
    chk("mw_retired", retired, 32'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("mr_pc", pc, 32'h0);
    chk("mr_retired", retired, 32'd0);
    chk("mr_instr", instr, 32'd0);
    chk("mr_req", {31'd0, im_req}, 32'd0);
    chk("mr_flags", {29'd0, halted, bus_err, align_err}, 32'd0);
    im_ack = 1'b1; im_rdata = 32'hBAD0_BAD0;
    step();
    im_ack = 1'b0;
    chk("mr_late_ack", instr, 32'd0);
    chk("mr_req_idle", {31'd0, im_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
